// File: rtl/move_controller.sv
// Player move controller: bounds-checks one move at a time, reads the target
// tile, updates the player position and emits in-grid neighbours for reveal.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   cmd_valid/ready    move command handshake, cmd_dir 0=up 1=down 2=left 3=right
//   map_rd/addr/data   map read port, data valid one cycle after map_rd
//   pos                current player index (row*MAP_W+col)
//   reveal_valid/addr  one neighbour cell per cycle after each position change
//   move_done, blocked one-cycle result pulses; at_exit sticky on EXIT tile
module move_controller #(
   parameter int MAP_W     = 10,
   parameter int MAP_H     = 10,
   parameter int START_POS = 50
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   input  logic [1:0]  cmd_dir,
   output logic        cmd_ready,
   output logic        map_rd,
   output logic [15:0] map_addr,
   input  logic [15:0] map_data,
   output logic [15:0] pos,
   output logic        reveal_valid,
   output logic [15:0] reveal_addr,
   output logic        move_done,
   output logic        blocked,
   output logic        at_exit
);

   localparam logic [15:0] W  = 16'(MAP_W);
   localparam logic [15:0] H  = 16'(MAP_H);
   localparam logic [15:0] SP = 16'(START_POS);

   typedef enum logic [2:0] {
      S_REVEAL,
      S_IDLE,
      S_FETCH,
      S_CHECK,
      S_BLOCK,
      S_DONE
   } state_t;

   state_t      state_q;
   logic [15:0] pos_q;
   logic [15:0] tgt_q;
   logic [2:0]  idx_q;
   logic        cmd_ready_q;
   logic        map_rd_q;
   logic [15:0] map_addr_q;
   logic        reveal_valid_q;
   logic [15:0] reveal_addr_q;
   logic        move_done_q;
   logic        blocked_q;
   logic        at_exit_q;

   logic [15:0] row;
   logic [15:0] col;
   logic [3:0]  nb_ok;
   logic [15:0] nb_addr [4];
   logic        nb_found;
   logic [1:0]  nb_sel;
   logic        edge_d;
   logic [15:0] tgt_d;
   logic        pass;

   assign row = pos_q / W;
   assign col = pos_q % W;

   // Neighbour order up, down, left, right. Validity comes from row/col so
   // a right step from the last column never wraps into the next row.
   always_comb begin
      nb_ok[0]   = (row != 16'd0);
      nb_ok[1]   = (row != H - 16'd1);
      nb_ok[2]   = (col != 16'd0);
      nb_ok[3]   = (col != W - 16'd1);
      nb_addr[0] = pos_q - W;
      nb_addr[1] = pos_q + W;
      nb_addr[2] = pos_q - 16'd1;
      nb_addr[3] = pos_q + 16'd1;
   end

   // A command direction maps directly onto the neighbour table.
   assign edge_d = !nb_ok[cmd_dir];
   assign tgt_d  = nb_addr[cmd_dir];

   // First in-grid neighbour at or after the sweep index; skipped entries
   // cost no cycle.
   always_comb begin
      nb_found = 1'b0;
      nb_sel   = 2'd0;
      for (int k = 0; k < 4; k++) begin
         if (!nb_found && (3'(k) >= idx_q) && nb_ok[k]) begin
            nb_found = 1'b1;
            nb_sel   = 2'(k);
         end
      end
   end

   assign pass = (map_data != 16'd0) && (map_data <= 16'd4);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_REVEAL;
         pos_q          <= SP;
         tgt_q          <= 16'd0;
         idx_q          <= 3'd0;
         cmd_ready_q    <= 1'b0;
         map_rd_q       <= 1'b0;
         map_addr_q     <= 16'd0;
         reveal_valid_q <= 1'b0;
         reveal_addr_q  <= 16'd0;
         move_done_q    <= 1'b0;
         blocked_q      <= 1'b0;
         at_exit_q      <= 1'b0;
      end else begin
         map_rd_q       <= 1'b0;
         reveal_valid_q <= 1'b0;
         move_done_q    <= 1'b0;
         blocked_q      <= 1'b0;
         unique case (state_q)
            S_REVEAL: begin
               if (nb_found) begin
                  reveal_valid_q <= 1'b1;
                  reveal_addr_q  <= nb_addr[nb_sel];
                  idx_q          <= 3'(nb_sel) + 3'd1;
               end else begin
                  state_q     <= S_IDLE;
                  cmd_ready_q <= 1'b1;
               end
            end
            S_IDLE: begin
               if (cmd_valid) begin
                  cmd_ready_q <= 1'b0;
                  if (edge_d) begin
                     state_q   <= S_BLOCK;
                     blocked_q <= 1'b1;
                  end else begin
                     state_q    <= S_FETCH;
                     tgt_q      <= tgt_d;
                     map_rd_q   <= 1'b1;
                     map_addr_q <= tgt_d;
                  end
               end
            end
            S_FETCH: begin
               state_q <= S_CHECK;
            end
            S_CHECK: begin
               if (pass) begin
                  pos_q       <= tgt_q;
                  move_done_q <= 1'b1;
                  if (map_data == 16'd3) begin
                     at_exit_q <= 1'b1;
                     state_q   <= S_DONE;
                  end else begin
                     idx_q   <= 3'd0;
                     state_q <= S_REVEAL;
                  end
               end else begin
                  blocked_q <= 1'b1;
                  state_q   <= S_BLOCK;
               end
            end
            S_BLOCK: begin
               state_q     <= S_IDLE;
               cmd_ready_q <= 1'b1;
            end
            S_DONE: begin
               state_q <= S_DONE;
            end
            default: begin
               state_q <= S_REVEAL;
               idx_q   <= 3'd0;
            end
         endcase
      end
   end

   assign cmd_ready    = cmd_ready_q;
   assign map_rd       = map_rd_q;
   assign map_addr     = map_addr_q;
   assign pos          = pos_q;
   assign reveal_valid = reveal_valid_q;
   assign reveal_addr  = reveal_addr_q;
   assign move_done    = move_done_q;
   assign blocked      = blocked_q;
   assign at_exit      = at_exit_q;

endmodule

// File: tb/tb_move_controller.sv
// Bench for move_controller: random and directed moves on a 10x10 map,
// expected output events queued by a grid-level model, popped by a monitor.
module tb_move_controller;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [1:0]  cmd_dir = 2'd0;
   logic        cmd_ready;
   logic        map_rd;
   logic [15:0] map_addr;
   logic [15:0] map_data = 16'd0;
   logic [15:0] pos;
   logic        reveal_valid;
   logic [15:0] reveal_addr;
   logic        move_done;
   logic        blocked;
   logic        at_exit;

   move_controller #(
      .MAP_W(10),
      .MAP_H(10),
      .START_POS(50)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .cmd_valid(cmd_valid),
      .cmd_dir(cmd_dir),
      .cmd_ready(cmd_ready),
      .map_rd(map_rd),
      .map_addr(map_addr),
      .map_data(map_data),
      .pos(pos),
      .reveal_valid(reveal_valid),
      .reveal_addr(reveal_addr),
      .move_done(move_done),
      .blocked(blocked),
      .at_exit(at_exit)
   );

   always #5 clk = ~clk;

   localparam int K_RD = 0, K_BLK = 1, K_DONE = 2, K_REV = 3, K_RDY = 4;

   typedef struct {
      int k;
      int v;
      int d;
      bit x;
   } ev_t;

   ev_t q[$];
   int  total = 0;
   int  bad = 0;
   int  cyc = 0;
   int  last = 0;
   int  rev_cnt = 0;
   bit  rdy_prev = 1'b0;
   int  mem[100];
   int  mpos = 50;
   bit  mex = 1'b0;

   // Map read port: data valid exactly one cycle after the strobe.
   always @(posedge clk)
      map_data <= (map_rd && map_addr < 16'd100) ? 16'(mem[map_addr]) : 16'($urandom);

   task automatic chk(string n, int a, int e);
      total++;
      if (a != e) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", n, a, e);
      end
   endtask

   task automatic push(int k, int v, int d);
      ev_t e;
      e.k = k;
      e.v = v;
      e.d = d;
      e.x = mex;
      q.push_back(e);
   endtask

   task automatic push_sweep(int first);
      int r, c, d;
      r = mpos / 10;
      c = mpos % 10;
      d = first;
      if (r > 0) begin push(K_REV, mpos - 10, d); d = 1; end
      if (r < 9) begin push(K_REV, mpos + 10, d); d = 1; end
      if (c > 0) begin push(K_REV, mpos - 1, d); d = 1; end
      if (c < 9) begin push(K_REV, mpos + 1, d); d = 1; end
      push(K_RDY, mpos, 1);
   endtask

   task automatic model(int dir);
      int r, c, t;
      bit at_edge;
      r = mpos / 10;
      c = mpos % 10;
      case (dir)
         0: begin at_edge = (r == 0); t = mpos - 10; end
         1: begin at_edge = (r == 9); t = mpos + 10; end
         2: begin at_edge = (c == 0); t = mpos - 1; end
         default: begin at_edge = (c == 9); t = mpos + 1; end
      endcase
      if (at_edge) begin
         push(K_BLK, mpos, 1);
         push(K_RDY, mpos, 1);
      end else begin
         push(K_RD, t, 1);
         if (mem[t] >= 1 && mem[t] <= 4) begin
            mpos = t;
            if (mem[t] == 3) mex = 1'b1;
            push(K_DONE, t, 2);
            if (!mex) push_sweep(1);
         end else begin
            push(K_BLK, mpos, 2);
            push(K_RDY, mpos, 1);
         end
      end
   endtask

   task automatic see(int k, int v);
      ev_t e;
      int  gap;
      total++;
      gap  = cyc - last;
      last = cyc;
      if (q.size() == 0) begin
         bad++;
         $display("FAIL unexpected: kind=%0d val=%0d cyc=%0d", k, v, cyc);
         return;
      end
      e = q.pop_front();
      if (e.k != k || e.v != v || (e.d >= 0 && gap != e.d) || at_exit != e.x) begin
         bad++;
         $display("FAIL event: got kind=%0d val=%0d gap=%0d exit=%0b want kind=%0d val=%0d gap=%0d exit=%0b",
                  k, v, gap, at_exit, e.k, e.v, e.d, e.x);
      end
   endtask

   // Monitor: every output event is matched in order against the queue.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            rdy_prev = 1'b0;
         end else begin
            cyc++;
            if (cmd_valid && cmd_ready) last = cyc;
            if (map_rd) see(K_RD, int'(map_addr));
            if (blocked) see(K_BLK, int'(pos));
            if (move_done) see(K_DONE, int'(pos));
            if (reveal_valid) begin
               see(K_REV, int'(reveal_addr));
               rev_cnt++;
            end
            if (cmd_ready && !rdy_prev) see(K_RDY, int'(pos));
            rdy_prev = cmd_ready;
         end
      end
   end

   task automatic wait_idle(string n);
      for (int i = 0; i < 60 && q.size() != 0; i++) @(posedge clk);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL %s: %0d events still pending", n, q.size());
         q.delete();
      end
   endtask

   task automatic issue(int dir, string n);
      wait_idle(n);
      @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_dir   = 2'(dir);
      model(dir);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic goto(int tgt);
      int tr, tc, r, c, d;
      tr = tgt / 10;
      tc = tgt % 10;
      for (int g = 0; g < 40 && mpos != tgt; g++) begin
         r = mpos / 10;
         c = mpos % 10;
         if (r > tr) d = 0;
         else if (r < tr) d = 1;
         else if (c > tc) d = 2;
         else d = 3;
         issue(d, "goto");
      end
      wait_idle("goto_end");
   endtask

   initial begin
      int base;
      for (int i = 0; i < 100; i++) mem[i] = 4;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_pos", int'(pos), 50);
      chk("rst_ready", int'(cmd_ready), 0);
      chk("rst_rd", int'(map_rd), 0);
      chk("rst_rv", int'(reveal_valid), 0);
      chk("rst_done", int'(move_done), 0);
      chk("rst_blk", int'(blocked), 0);
      chk("rst_exit", int'(at_exit), 0);
      chk("rst_maddr", int'(map_addr), 0);
      chk("rst_raddr", int'(reveal_addr), 0);

      push_sweep(-1);
      rst_n = 1'b1;
      wait_idle("sweep");
      chk("pos_after_sweep", int'(pos), 50);

      issue(2, "left50");
      wait_idle("left50");
      chk("pos_left50", int'(pos), 50);

      issue(3, "right50");
      wait_idle("right50");
      chk("pos_right50", int'(pos), 51);

      mem[52] = 5;
      issue(3, "wall52");
      wait_idle("wall52");
      mem[52] = 0;
      issue(3, "unknown52");
      wait_idle("unknown52");
      chk("pos_blocked52", int'(pos), 51);

      for (int n = 0; n < 100; n++) begin
         wait_idle("rnd");
         if (n % 25 == 0) begin
            for (int i = 0; i < 100; i++) begin
               mem[i] = $urandom_range(0, 7);
               if (mem[i] == 3) mem[i] = 4;
            end
         end
         issue($urandom_range(0, 3), "rnd");
      end
      wait_idle("rnd_end");
      chk("pos_rnd", int'(pos), mpos);

      for (int i = 0; i < 100; i++) mem[i] = 4;
      goto(9);
      issue(3, "right9_nowrap");
      wait_idle("right9");
      chk("pos_right9", int'(pos), 9);
      goto(90);
      issue(1, "down90");
      issue(2, "left90");
      wait_idle("edge90");
      chk("pos_edge90", int'(pos), 90);

      base = rev_cnt;
      issue(0, "up90");
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         if (rev_cnt >= base + 2) break;
      end
      chk("reach_2nd_reveal", int'(rev_cnt >= base + 2), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_pos", int'(pos), 50);
      chk("mid_rst_rv", int'(reveal_valid), 0);
      chk("mid_rst_done", int'(move_done), 0);
      chk("mid_rst_ready", int'(cmd_ready), 0);
      chk("mid_rst_raddr", int'(reveal_addr), 0);
      q.delete();
      mpos = 50;
      mex  = 1'b0;
      @(posedge clk);
      #1;
      push_sweep(-1);
      rst_n = 1'b1;
      wait_idle("sweep2");

      goto(58);
      mem[59] = 3;
      issue(3, "exit59");
      wait_idle("exit59");
      chk("pos_exit", int'(pos), 59);
      chk("at_exit", int'(at_exit), 1);

      @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_dir   = 2'd2;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("done_ready", int'(cmd_ready), 0);
      end
      chk("done_exit_sticky", int'(at_exit), 1);
      chk("done_pos", int'(pos), 59);
      cmd_valid = 1'b0;
      repeat (2) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
